// File: rtl/cla_seq_divider_pkg.sv
// Shared types for the sequential CLA divider: FSM state encoding and counter sizing.
// Imported by the divider top level.
package cla_seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter counts WIDTH-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational N-bit subtractor a + ~b + 1 using full generate/propagate carry lookahead.
// no_borrow is the carry out of the top bit (1 when a >= b).
module cla_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry is expanded as a sum of products of g/p terms and carry-in=1.
  always_comb begin
    logic run;
    logic acc;
    run  = 1'b0;
    acc  = 1'b0;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      acc = g[i];
      run = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      c[i+1] = acc | run;
    end
  end

  assign diff      = p ^ c[N-1:0];
  assign no_borrow = c[N];

endmodule

// File: rtl/cla_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock via a CLA trial subtractor.
// Result valid WIDTH+1 cycles after the input handshake (1 cycle for divide-by-zero).
module cla_seq_divider
  import cla_seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             no_borrow;

  assign trial_a = {rem_q, q_q[WIDTH-1]};
  assign trial_b = {1'b0, dvs_q};

  cla_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a         (trial_a),
    .b         (trial_b),
    .diff      (trial_diff),
    .no_borrow (no_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            q_d     = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // On a no-borrow step the difference is below the divisor, so its top bit is 0.
        if (no_borrow) begin
          rem_d = trial_diff[WIDTH-1:0] | {WIDTH{trial_diff[WIDTH]}};
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial_a[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cla_seq_divider.sv
// Randomised and directed bench for cla_seq_divider (WIDTH=4) against an arithmetic reference.
// Results, latency, backpressure hold and asynchronous reset abort are all checked.
module tb_cla_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  cla_seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full transaction: handshake, latency, result, optional backpressure, output handshake.
  task automatic run_op(input int a, input int b, input int bp);
    int           n;
    logic [W-1:0] eq, er;
    logic         edbz;
    if (b == 0) begin
      eq = '1; er = W'(a); edbz = 1'b1;
    end else begin
      eq = W'(a / b); er = W'(a % b); edbz = 1'b0;
    end

    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("ready_before_op", {31'd0, in_ready}, 32'd1);

    dividend  = W'(a);
    divisor   = W'(b);
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);

    n = 1;
    while (!out_valid && n < 40) begin
      check_eq("busy_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1; n++;
    end
    check_eq("latency", n, (b == 0) ? 32'd1 : 32'(W + 1));
    check_eq("quotient", {28'd0, quotient}, {28'd0, eq});
    check_eq("remainder", {28'd0, remainder}, {28'd0, er});
    check_eq("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
    if (b != 0) check_eq("rem_lt_divisor", {31'd0, (32'(remainder) < b)}, 32'd1);

    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_hold", {23'd0, quotient, remainder, div_by_zero}, {23'd0, eq, er, edbz});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_results", {23'd0, quotient, remainder, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(9, 3, 0);
    run_op(11, 6, 0);
    run_op(15, 1, 0);
    run_op(6, 9, 0);
    run_op(0, 7, 0);
    run_op(5, 0, 0);
    run_op(9, 3, 0);
    run_op(7, 2, 10);
    run_op(12, 0, 3);

    // Abort 13/2 with an asynchronous reset between edges at cycle 2.
    dividend = 4'd13;
    divisor  = 4'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("abort_results", {23'd0, quotient, remainder, div_by_zero}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 32'd0);
    out_ready = 1'b0;
    run_op(13, 2, 0);

    for (int k = 0; k < 40; k++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      run_op(a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
